// File: rtl/task2_sweep_ctrl.sv
// Clocked sweep sequencer for the Task2 block: applies all 16 vectors,
// checks x/y against truth-table masks. Option macro: TASK2_STOP_ON_FAIL_EN.
module task2_sweep_ctrl #(
  parameter int unsigned  SETTLE_CYCLES = 2,
  parameter logic [15:0]  X_MASK        = 16'hCF00,
  parameter logic [15:0]  Y_MASK        = 16'h0F54
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       x_in,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic       fail_seen,
  output logic [3:0] first_fail_idx
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    FINISH
  } state_t;

  localparam logic [7:0] SETTLE_INIT = SETTLE_CYCLES[7:0];

`ifdef TASK2_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_t     state;
  state_t     state_nxt;
  logic [3:0] idx;
  logic [3:0] idx_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic [3:0] vec;
  logic [3:0] vec_nxt;
  logic       busy_nxt;
  logic       done_nxt;
  logic       pass_nxt;
  logic [5:0] err_nxt;
  logic       fs_nxt;
  logic [3:0] ffi_nxt;

  logic mx;
  logic my;
  logic mism;

  assign mx   = x_in != X_MASK[idx];
  assign my   = y_in != Y_MASK[idx];
  assign mism = mx | my;

  assign a = vec[3];
  assign b = vec[2];
  assign c = vec[1];
  assign d = vec[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt == 8'd1) state_nxt = CHECK;
      end
      CHECK: begin
        if (idx == 4'd15 || (STOP_ON_FAIL && mism))
          state_nxt = FINISH;
        else
          state_nxt = SETTLE;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the datapath and result registers
  always_comb begin
    idx_nxt  = idx;
    cnt_nxt  = cnt;
    vec_nxt  = vec;
    busy_nxt = busy;
    done_nxt = 1'b0;
    pass_nxt = pass;
    err_nxt  = err_count;
    fs_nxt   = fail_seen;
    ffi_nxt  = first_fail_idx;
    unique case (state)
      IDLE: begin
        if (start) begin
          idx_nxt  = 4'd0;
          vec_nxt  = 4'd0;
          cnt_nxt  = SETTLE_INIT;
          err_nxt  = 6'd0;
          fs_nxt   = 1'b0;
          ffi_nxt  = 4'd0;
          pass_nxt = 1'b0;
          busy_nxt = 1'b1;
        end
      end
      SETTLE: begin
        cnt_nxt = cnt - 8'd1;
      end
      CHECK: begin
        err_nxt = err_count + {5'd0, mx} + {5'd0, my};
        if (mism && !fail_seen) begin
          ffi_nxt = idx;
          fs_nxt  = 1'b1;
        end
        if (state_nxt == SETTLE) begin
          idx_nxt = idx + 4'd1;
          vec_nxt = idx + 4'd1;
          cnt_nxt = SETTLE_INIT;
        end
      end
      FINISH: begin
        done_nxt = 1'b1;
        busy_nxt = 1'b0;
        pass_nxt = err_count == 6'd0;
        vec_nxt  = 4'd0;
      end
      default: ;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx            <= 4'd0;
      cnt            <= 8'd0;
      vec            <= 4'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 6'd0;
      fail_seen      <= 1'b0;
      first_fail_idx <= 4'd0;
    end else begin
      idx            <= idx_nxt;
      cnt            <= cnt_nxt;
      vec            <= vec_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
      err_count      <= err_nxt;
      fail_seen      <= fs_nxt;
      first_fail_idx <= ffi_nxt;
    end
  end

endmodule

// File: doc/task2_sweep_ctrl.md
# task2_sweep_ctrl

Sequencer that drives the 4-input/2-output `Task2` combinational block through all 16 input vectors and checks its `x`/`y` outputs against parameterised truth-table masks. It sits between a control source (switch, pushbutton or host) and `Task2`, giving an on-chip, clocked replacement for the simulation-only sweep. It reports a pass/fail flag, an error count and the first failing vector.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: clocks each vector is held before it is sampled; legal range 1–255; 0 is illegal.
- `X_MASK`, default 16'hCF00: expected `x` for vector i is `X_MASK[i]`.
- `Y_MASK`, default 16'h0F54: expected `y` for vector i is `Y_MASK[i]`.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled request to begin a sweep.
- `a`, `b`, `c`, `d` out 1 each: drive the `Task2` inputs. Vector index i = {a,b,c,d}; `a` is the MSB.
- `x_in`, `y_in` in 1 each: `Task2` outputs.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse at the end of a sweep.
- `pass` out 1: result of the last completed sweep.
- `err_count` out 6: number of mismatches. Each vector can add 0–2; maximum 32.
- `fail_seen` out 1: at least one mismatch has occurred in the current or last sweep.
- `first_fail_idx` out 4: index of the first mismatching vector; valid when `fail_seen`=1.

## Operation
- States: IDLE, SETTLE, CHECK, DONE. Internal registers: `idx[3:0]` and `cnt[7:0]`.
- IDLE:
  - `start`=1 → `idx`←0, `{a,b,c,d}`←0, `cnt`←SETTLE_CYCLES, `err_count`←0, `fail_seen`←0, `first_fail_idx`←0, `pass`←0, `busy`←1 → SETTLE.
  - Otherwise hold; result outputs keep the last sweep's values.
- SETTLE: `cnt`←`cnt`−1; when `cnt`=1 → CHECK. The vector is held for exactly SETTLE_CYCLES clocks.
- CHECK, on the sampling edge:
  - `mx` = `x_in`≠`X_MASK[idx]`; `my` = `y_in`≠`Y_MASK[idx]`.
  - `err_count` += `mx`+`my`.
  - If (`mx`|`my`) and `fail_seen`=0: `first_fail_idx`←`idx`, `fail_seen`←1.
  - If `idx`=15 → DONE. Otherwise `idx`←`idx`+1, drive the new vector, `cnt`←SETTLE_CYCLES → SETTLE.
- DONE: `done`=1 for this cycle only; `busy`←0; `pass`←(`err_count`=0); `{a,b,c,d}`←0 → IDLE.
- `start` is ignored in SETTLE, CHECK and DONE. Requests are not queued.
- Mask bit i corresponds to i = 8a+4b+2c+d.

## Timing
- Reset values of all outputs: `a`=`b`=`c`=`d`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_seen`=0, `first_fail_idx`=0. State is IDLE.
- `busy` rises on the edge that samples `start`.
- Each vector occupies SETTLE_CYCLES+1 clocks.
- `done` is asserted 16·(SETTLE_CYCLES+1)+1 clocks after the start edge: 49 with the default setting.
- `pass`, `err_count`, `fail_seen` and `first_fail_idx` are valid from the `done` cycle and are held until the next accepted `start`.
- `err_count` saturation is not needed; 6 bits covers the maximum of 32.
- Reset asserted mid-sweep: outputs return to their reset values immediately (asynchronously). No partial result is retained.
- `start` held high continuously: a new sweep begins on the first IDLE cycle after DONE, so there is exactly one idle cycle between sweeps.

## Configuration
- `TASK2_STOP_ON_FAIL_EN` defined:
  - A CHECK with any mismatch goes directly to DONE, after updating `err_count` (1 or 2) and `first_fail_idx`.
  - `done` then pulses early, `pass`=0, and the remaining vectors are not applied.
- Not defined: all 16 vectors are always applied and `err_count` reflects the full sweep.

## Test plan
- Correct `Task2` model, SETTLE_CYCLES=2, `start` pulse:
  - `done` pulses 49 clocks later.
  - `pass`=1, `err_count`=0, `fail_seen`=0.
  - `{a,b,c,d}` steps 0→15, each vector held 3 clocks.
- Model with `y` inverted at vector 5 only → `err_count`=1, `fail_seen`=1, `first_fail_idx`=5, `pass`=0.
- Model with `x` stuck at 0 → `err_count`=6, `first_fail_idx`=8, `pass`=0.
- Same stuck-at-0 model with `TASK2_STOP_ON_FAIL_EN` defined → `done` pulses after 9·3+1=28 clocks, `err_count`=1, `first_fail_idx`=8.
- `start` reasserted at clock 10 of a sweep → ignored, `done` still at 49. Then `rst_n` low at clock 20 of a new sweep → all outputs return to 0 and `busy`=0 immediately.
- `start` held high across two sweeps → second `busy` rises 1 clock after the first `done`. `err_count` is cleared at the second start.
